// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed 4-digit seven-segment driver.
package seg_pkg;

  typedef enum logic {
    GAP  = 1'b0,
    SHOW = 1'b1
  } scan_state_e;

  localparam int unsigned NUM_DIGITS = 4;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_DASH = 7'h3F;

  // Entry k holds the pattern for BCD value k (entry 0 is the rightmost slice).
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
    7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low seven-segment decoder; non-BCD codes show a dash.
module bcd_to_seg7
  import seg_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_DASH;
    if (i_bcd < 4'd10) o_seg = SEG_TABLE[i_bcd];
  end

endmodule

// File: rtl/seg_display_mux.sv
// Time-multiplexed 4-digit display driver with blanking gap, snapshotting,
// leading-zero blanking and a global blank.
module seg_display_mux
  import seg_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLANK_CYC   = 2000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  input  logic [3:0] dp_sel,
  input  logic       lzb,
  input  logic       blank,
  output logic [7:0] seg,
  output logic       decimal,
  output logic [3:0] an
);

  localparam int unsigned   CW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_SHOW = CW'(BLANK_CYC);

  logic [CW-1:0]                 r_cnt, w_cnt_nxt;
  logic [1:0]                    r_idx, w_idx_nxt;
  scan_state_e                   r_state, w_state_nxt;
  logic [NUM_DIGITS-1:0][3:0]    r_snap_d, w_snap_d_nxt;
  logic [NUM_DIGITS-1:0]         r_snap_dp, w_snap_dp_nxt;
  logic                          w_wrap;
  logic [3:0]                    w_digit;
  logic [6:0]                    w_seg7;
  logic [NUM_DIGITS-1:0]         w_zero_hi;
  logic                          w_dark;
  logic [7:0]                    w_seg_nxt;
  logic                          w_dec_nxt;
  logic [3:0]                    w_an_nxt;

  always_comb begin
    w_wrap    = (r_cnt == CNT_LAST);
    w_cnt_nxt = w_wrap ? '0 : r_cnt + CW'(1);
    w_idx_nxt = w_wrap ? r_idx + 2'd1 : r_idx;

    w_state_nxt = r_state;
    case (r_state)
      GAP:  if (w_cnt_nxt == CNT_SHOW) w_state_nxt = SHOW;
      SHOW: if (w_wrap) w_state_nxt = GAP;
    endcase

    w_snap_d_nxt  = r_snap_d;
    w_snap_dp_nxt = r_snap_dp;
    if (r_cnt == '0 && r_idx == 2'd0) begin
      w_snap_d_nxt  = {d3, d2, d1, d0};
      w_snap_dp_nxt = dp_sel;
    end
  end

  // Outputs are computed from the next-cycle values so every registered
  // output lines up with the prescaler/index it appears alongside.
  assign w_digit = w_snap_d_nxt[w_idx_nxt];

  bcd_to_seg7 u_dec (
    .i_bcd (w_digit),
    .o_seg (w_seg7)
  );

  always_comb begin
    w_zero_hi[3] = (w_snap_d_nxt[3] == 4'd0) && !w_snap_dp_nxt[3];
    w_zero_hi[2] = w_zero_hi[3] && (w_snap_d_nxt[2] == 4'd0) && !w_snap_dp_nxt[2];
    w_zero_hi[1] = w_zero_hi[2] && (w_snap_d_nxt[1] == 4'd0) && !w_snap_dp_nxt[1];
    w_zero_hi[0] = w_zero_hi[1] && (w_snap_d_nxt[0] == 4'd0) && !w_snap_dp_nxt[0];
    w_dark       = lzb && (w_idx_nxt != 2'd0) && w_zero_hi[w_idx_nxt];

    w_an_nxt  = '1;
    w_seg_nxt = '1;
    w_dec_nxt = 1'b1;
    if (w_state_nxt == SHOW && !blank && !w_dark) begin
      w_an_nxt  = ~(4'b0001 << w_idx_nxt);
      w_seg_nxt = {1'b1, w_seg7};
      w_dec_nxt = ~w_snap_dp_nxt[w_idx_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt     <= '0;
      r_idx     <= '0;
      r_state   <= GAP;
      r_snap_d  <= '0;
      r_snap_dp <= '0;
      an        <= '1;
      seg       <= '1;
      decimal   <= 1'b1;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_idx     <= w_idx_nxt;
      r_state   <= w_state_nxt;
      r_snap_d  <= w_snap_d_nxt;
      r_snap_dp <= w_snap_dp_nxt;
      an        <= w_an_nxt;
      seg       <= w_seg_nxt;
      decimal   <= w_dec_nxt;
    end
  end

endmodule

// File: tb/tb_seg_display_mux.sv
// Directed bench for seg_display_mux with REFRESH_DIV=8, BLANK_CYC=2.
module tb_seg_display_mux;

  localparam int RD = 8;
  localparam int BC = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0, dp_sel = '0;
  logic       lzb = 1'b0, blank = 1'b0;
  logic [7:0] seg;
  logic       decimal;
  logic [3:0] an;

  int unsigned n_chk = 0, n_pass = 0;
  int          cyc = 0;
  logic [15:0] s_d = '0;
  logic [3:0]  s_dp = '0;
  logic        e_blank = 1'b0, e_lzb = 1'b0;
  logic [3:0]  ea;
  logic [7:0]  es;
  logic        ed;

  seg_display_mux #(.REFRESH_DIV(RD), .BLANK_CYC(BC)) dut (
    .clk(clk), .reset_n(reset_n), .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .dp_sel(dp_sel), .lzb(lzb), .blank(blank),
    .seg(seg), .decimal(decimal), .an(an)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [6:0] ref7(input logic [3:0] v);
    case (v)
      4'd0: ref7 = 7'h40; 4'd1: ref7 = 7'h79; 4'd2: ref7 = 7'h24;
      4'd3: ref7 = 7'h30; 4'd4: ref7 = 7'h19; 4'd5: ref7 = 7'h12;
      4'd6: ref7 = 7'h02; 4'd7: ref7 = 7'h78; 4'd8: ref7 = 7'h00;
      4'd9: ref7 = 7'h10; default: ref7 = 7'h3F;
    endcase
  endfunction

  // Reference behaviour for the cycle currently visible on the outputs.
  task automatic expect_now(output logic [3:0] xa, output logic [7:0] xs, output logic xd);
    int slot, p;
    logic dark;
    logic [3:0] dig;
    slot = (cyc / RD) % 4;
    p    = cyc % RD;
    dig  = s_d[slot*4 +: 4];
    dark = 1'b0;
    if (e_lzb && slot != 0) begin
      dark = 1'b1;
      for (int k = slot; k < 4; k++)
        if (s_d[k*4 +: 4] != 4'd0 || s_dp[k]) dark = 1'b0;
    end
    xa = 4'hF; xs = 8'hFF; xd = 1'b1;
    if (p >= BC && !e_blank && !dark) begin
      xa = ~(4'b0001 << slot);
      xs = {1'b1, ref7(dig)};
      xd = ~s_dp[slot];
    end
  endtask

  task automatic tick();
    logic rs, bl, lz;
    rs = reset_n; bl = blank; lz = lzb;
    if (rs && (cyc % 32) == 0) begin
      s_d  = {d3, d2, d1, d0};
      s_dp = dp_sel;
    end
    @(posedge clk);
    if (!rs) begin
      cyc = 0; s_d = '0; s_dp = '0; e_blank = 1'b0;
    end else begin
      cyc++; e_blank = bl;
    end
    e_lzb = lz;
    #1;
  endtask

  task automatic test_reset();
    d3 = 4'd1; d2 = 4'd2; d1 = 4'd3; d0 = 4'd4; dp_sel = '0; lzb = 0; blank = 0;
    reset_n = 1'b0;
    repeat (3) begin
      tick();
      n_chk++;
      if (an !== 4'hF || seg !== 8'hFF || decimal !== 1'b1)
        $display("FAIL reset an=%b seg=%h dp=%b required 1111/ff/1", an, seg, decimal);
      else n_pass++;
    end
    reset_n = 1'b1;
  endtask

  task automatic test_scan();
    for (int i = 0; i <= 33; i++) begin
      expect_now(ea, es, ed);
      n_chk++;
      if (an !== ea || seg !== es || decimal !== ed)
        $display("FAIL scan cyc=%0d an=%b/%b seg=%h/%h dp=%b/%b", cyc, an, ea, seg, es, decimal, ed);
      else n_pass++;
      n_chk++;
      if ($countones(~an) > 1) $display("FAIL onehot cyc=%0d an=%b required at most one low", cyc, an);
      else n_pass++;
      if (cyc == 1 || cyc == 2 || cyc == 10 || cyc == 26 || cyc == 32) begin
        n_chk++;
        if ((cyc == 1  && an !== 4'b1111) ||
            (cyc == 2  && (an !== 4'b1110 || seg !== 8'h99)) ||
            (cyc == 10 && (an !== 4'b1101 || seg !== 8'hB0)) ||
            (cyc == 26 && (an !== 4'b0111 || seg !== 8'hF9)) ||
            (cyc == 32 && an !== 4'b1111))
          $display("FAIL scan_fixed cyc=%0d an=%b seg=%h", cyc, an, seg);
        else n_pass++;
      end
      if (i < 33) tick();
    end
  endtask

  task automatic test_snapshot();
    while (cyc < 50) tick();
    d0 = 4'd7;
    while (cyc < 72) begin
      tick();
      expect_now(ea, es, ed);
      n_chk++;
      if (an !== ea || seg !== es || decimal !== ed)
        $display("FAIL snapshot cyc=%0d an=%b/%b seg=%h/%h dp=%b/%b", cyc, an, ea, seg, es, decimal, ed);
      else n_pass++;
      if (cyc == 58 || cyc == 66) begin
        n_chk++;
        if ((cyc == 58 && (an !== 4'b0111 || seg !== 8'hF9)) ||
            (cyc == 66 && (an !== 4'b1110 || seg !== 8'hF8)))
          $display("FAIL snapshot_fixed cyc=%0d an=%b seg=%h", cyc, an, seg);
        else n_pass++;
      end
    end
  endtask

  task automatic test_lzb();
    lzb = 1'b1; d3 = 0; d2 = 0; d1 = 0; d0 = 4'd5; dp_sel = '0;
    while (cyc < 160) begin
      if (cyc == 120) dp_sel = 4'b0100;
      tick();
      expect_now(ea, es, ed);
      n_chk++;
      if (an !== ea || seg !== es || decimal !== ed)
        $display("FAIL lzb cyc=%0d an=%b/%b seg=%h/%h dp=%b/%b", cyc, an, ea, seg, es, decimal, ed);
      else n_pass++;
      if (cyc == 98 || cyc == 106 || cyc == 114 || cyc == 122 ||
          cyc == 138 || cyc == 146 || cyc == 154) begin
        n_chk++;
        if ((cyc == 98  && (an !== 4'b1110 || seg !== 8'h92)) ||
            ((cyc == 106 || cyc == 114 || cyc == 122 || cyc == 154) && an !== 4'b1111) ||
            (cyc == 138 && (an !== 4'b1101 || seg !== 8'hC0 || decimal !== 1'b1)) ||
            (cyc == 146 && (an !== 4'b1011 || seg !== 8'hC0 || decimal !== 1'b0)))
          $display("FAIL lzb_fixed cyc=%0d an=%b seg=%h dp=%b", cyc, an, seg, decimal);
        else n_pass++;
      end
    end
  endtask

  task automatic test_dash();
    lzb = 1'b0; dp_sel = '0; d1 = 4'hC;
    while (cyc < 192) begin
      tick();
      expect_now(ea, es, ed);
      n_chk++;
      if (an !== ea || seg !== es || decimal !== ed)
        $display("FAIL dash cyc=%0d an=%b/%b seg=%h/%h dp=%b/%b", cyc, an, ea, seg, es, decimal, ed);
      else n_pass++;
      if (cyc == 170) begin
        n_chk++;
        if (an !== 4'b1101 || seg !== 8'hBF)
          $display("FAIL dash_fixed an=%b seg=%h required 1101/bf", an, seg);
        else n_pass++;
      end
    end
  endtask

  task automatic test_blank();
    while (cyc < 224) begin
      if (cyc == 194) blank = 1'b1;
      if (cyc == 199) blank = 1'b0;
      tick();
      expect_now(ea, es, ed);
      n_chk++;
      if (an !== ea || seg !== es || decimal !== ed)
        $display("FAIL blank cyc=%0d an=%b/%b seg=%h/%h dp=%b/%b", cyc, an, ea, seg, es, decimal, ed);
      else n_pass++;
      if ((cyc >= 195 && cyc <= 199) || cyc == 202) begin
        n_chk++;
        if ((cyc != 202 && (an !== 4'b1111 || seg !== 8'hFF)) ||
            (cyc == 202 && (an !== 4'b1101 || seg !== 8'hBF)))
          $display("FAIL blank_fixed cyc=%0d an=%b seg=%h", cyc, an, seg);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid();
    while (cyc < 245) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    n_chk++;
    if (an !== 4'hF || seg !== 8'hFF || decimal !== 1'b1 || cyc != 0)
      $display("FAIL reset_mid an=%b seg=%h dp=%b required 1111/ff/1", an, seg, decimal);
    else n_pass++;
    while (cyc < 34) begin
      tick();
      expect_now(ea, es, ed);
      n_chk++;
      if (an !== ea || seg !== es || decimal !== ed)
        $display("FAIL reset_mid cyc=%0d an=%b/%b seg=%h/%h dp=%b/%b", cyc, an, ea, seg, es, decimal, ed);
      else n_pass++;
      if (cyc == 1 || cyc == 2) begin
        n_chk++;
        if ((cyc == 1 && an !== 4'b1111) || (cyc == 2 && (an !== 4'b1110 || seg !== 8'h92)))
          $display("FAIL reset_mid_fixed cyc=%0d an=%b seg=%h", cyc, an, seg);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_snapshot();
    test_lzb();
    test_dash();
    test_blank();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/seg_display_mux.md
SEG_DISPLAY_MUX -- requirements
Module: seg_display_mux

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, clk cycles per digit slot (1 kHz slot rate at 100 MHz); legal range >= 4.
REQ-002 Parameter BLANK_CYC, default 2000, cycles per slot with all anodes off (anti-ghosting); legal range 1 .. REFRESH_DIV-2.
REQ-003 clk  input  1  sole clock; all flops update on the rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset.
REQ-005 d0, d1, d2, d3  input  4 each  BCD digits from the stopwatch counter; d0 is the rightmost digit.
REQ-006 dp_sel  input  4  one-hot decimal-point position; bit k lights the DP of digit k; 0 means no DP.
REQ-007 lzb  input  1  leading-zero blanking enable.
REQ-008 blank  input  1  forces the whole display dark.
REQ-009 seg  output  8  active-low segments; bits 6:0 = {g,f,e,d,c,b,a}; bit 7 is constant 1.
REQ-010 decimal  output  1  active-low decimal point.
REQ-011 an  output  4  active-low anodes; an[k] drives digit k.

Function
REQ-012 A prescaler SHALL count 0..REFRESH_DIV-1 and wrap to 0, advancing the scan index 0->1->2->3->0 on each wrap.
REQ-013 Each slot SHALL be a two-state FSM: GAP while prescaler < BLANK_CYC, then SHOW for the remaining REFRESH_DIV-BLANK_CYC cycles.
REQ-014 In GAP: an=4'b1111, seg=8'hFF, decimal=1.
REQ-015 In SHOW: an = all ones except bit[index]=0; seg = decoded snapshot digit; decimal = ~snap_dp[index].
REQ-016 On the first GAP cycle of slot 0, d0..d3 and dp_sel SHALL be captured into a snapshot; all four slots of that scan SHALL use only the snapshot (no tearing).
REQ-017 Decode table seg[6:0]: 0=40,1=79,2=24,3=30,4=19,5=12,6=02,7=78,8=00,9=10 (hex); codes 10-15 SHALL show a dash (3F).
REQ-018 With lzb=1, digit k (k=1..3) SHALL be dark (an[k] held 1 for its SHOW) iff snapshot digits k..3 are all 0 and snap_dp[k..3] are all 0; digit 0 SHALL never be blanked.
REQ-019 blank=1 SHALL force GAP-style outputs in the same cycle's registered update, without disturbing the prescaler, index or snapshot.
REQ-020 seg, decimal and an SHALL all be registered; each reflects the prescaler/index value it was computed from in the same cycle (no extra pipeline skew between outputs).
REQ-021 At most one an bit SHALL be low in any cycle.

Reset
REQ-022 While reset_n=0 at a clock edge: prescaler=0, index=0, state=GAP, snapshot=0, an=4'b1111, seg=8'hFF, decimal=1.
REQ-023 Reset asserted mid-slot SHALL take effect on the next edge; the first cycle after release SHALL be cycle 0 of slot 0 GAP, including a fresh snapshot capture.

Structure
REQ-024 Package seg_pkg SHALL hold: scan state enum {GAP, SHOW}, NUM_DIGITS=4, the SEG_DASH constant and the BCD-to-segment table.
REQ-025 Sub-module bcd_to_seg7 (combinational, 4-bit in, 7-bit active-low out) SHALL implement REQ-017; the mux SHALL instantiate it once on the selected snapshot digit.

Verification (REFRESH_DIV=8, BLANK_CYC=2)
REQ-026 Reset release, d3..d0=1,2,3,4, dp_sel=0, lzb=0 -> cycles 0-1 an=1111; cycles 2-7 an=1110, seg=99; cycles 10-15 an=1101, seg=B0; digit 3 an=0111, seg=F9; wrap to digit 0 at cycle 32.
REQ-027 Change d0 from 4 to 7 during slot 2 -> slot 3 still shows the old snapshot; the next slot 0 shows seg=F8.
REQ-028 lzb=1, d3..d0=0,0,0,5, dp_sel=0 -> an stays 1111 in slots 1-3; slot 0 an=1110, seg=92; with dp_sel=0100 -> digit 2 shows seg=C0, decimal=0; digit 3 dark.
REQ-029 d1=4'hC -> digit 1 SHOW seg=BF.
REQ-030 blank=1 for 5 cycles mid-SHOW -> an=1111, seg=FF during those cycles; scan timing unchanged after release.
REQ-031 reset_n=0 for one cycle at prescaler=5 of slot 2 -> next cycle all outputs off, index=0, prescaler=0; an=1110 two cycles after release.
